// File: rtl/core8_pkg.sv
// -----------------------------------------------------------------------------
// core8_pkg
// Shared definitions for the core8 sequencer:
//   - state_t     : sequencer state encoding (FETCH/DECODE/EXEC)
//   - OPC_*       : 6-bit opcodes found in ir[15:10]
//   - OP_*        : 4-bit ALU8 opcodes driven on the alu line
//   - ctrl_t      : decoded control word held between DECODE and EXEC
//   - mkCtrl      : helper that builds a legal control word
// No ports (package).
// -----------------------------------------------------------------------------
package core8_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_DECODE = 2'b01,
    ST_EXEC   = 2'b10
  } state_t;

  // Opcodes in ir[15:10]
  localparam logic [5:0] OPC_NOP = 6'b000000;
  localparam logic [5:0] OPC_CLC = 6'b000001;
  localparam logic [5:0] OPC_ADD = 6'b000011;
  localparam logic [5:0] OPC_CP  = 6'b000101;
  localparam logic [5:0] OPC_SUB = 6'b000110;
  localparam logic [5:0] OPC_ADC = 6'b000111;
  localparam logic [5:0] OPC_AND = 6'b001000;
  localparam logic [5:0] OPC_INC = 6'b001001;
  localparam logic [5:0] OPC_EOR = 6'b001010;
  localparam logic [5:0] OPC_OR  = 6'b001011;
  localparam logic [5:0] OPC_DEC = 6'b001100;

  // ALU8 operation codes
  localparam logic [3:0] OP_A    = 4'b1000;
  localparam logic [3:0] OP_INC  = 4'b1001;
  localparam logic [3:0] OP_DEC  = 4'b1010;
  localparam logic [3:0] OP_ADD  = 4'b1100;
  localparam logic [3:0] OP_ADC1 = 4'b1101;
  localparam logic [3:0] OP_SUB  = 4'b1111;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_EOR  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0100;

  // SREG clear masks (a 0 bit clears that flag)
  localparam logic [3:0] CLRF_NONE  = 4'b1111;
  localparam logic [3:0] CLRF_CARRY = 4'b1110;

  // useCarry marks ADC: the final ALU code is picked in EXEC from the live
  // carry flag, so the word only stores the carry-less base operation.
  typedef struct packed {
    logic [3:0] alu;
    logic       twoOp;
    logic       wr;
    logic       flagUpd;
    logic       useCarry;
    logic [3:0] clrf;
    logic       legal;
  } ctrl_t;

  localparam ctrl_t CTRL_ILLEGAL = '{OP_A, 1'b0, 1'b0, 1'b0, 1'b0, CLRF_NONE, 1'b0};

  function automatic ctrl_t mkCtrl(input logic [3:0] alu,
                                   input logic       twoOp,
                                   input logic       wr,
                                   input logic       flagUpd,
                                   input logic       useCarry,
                                   input logic [3:0] clrf);
    ctrl_t c;
    c.alu      = alu;
    c.twoOp    = twoOp;
    c.wr       = wr;
    c.flagUpd  = flagUpd;
    c.useCarry = useCarry;
    c.clrf     = clrf;
    c.legal    = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/core8_seq_if.sv
// -----------------------------------------------------------------------------
// core8_seq_if
// Bundles the sequencer's instruction-source handshake and datapath control
// lines.
//   master : the sequencer (drives fetch_req and all datapath controls,
//            receives run, fetch_ack, ir and flg)
//   slave  : instruction source + datapath side
// Parameter CNT_W : width of the retired-instruction counter icount.
// -----------------------------------------------------------------------------
interface core8_seq_if #(parameter int CNT_W = 16);

  logic             run;
  logic             fetch_ack;
  logic [15:0]      ir;
  logic [3:0]       flg;
  logic             fetch_req;
  logic             irie;
  logic             raoe;
  logic             rboe;
  logic [3:0]       rb;
  logic             sel;
  logic             sie;
  logic [3:0]       alu;
  logic [3:0]       clrf;
  logic             retire;
  logic             illegal;
  logic [1:0]       state;
  logic [CNT_W-1:0] icount;

  modport master (
    input  run, fetch_ack, ir, flg,
    output fetch_req, irie, raoe, rboe, rb, sel, sie, alu, clrf,
           retire, illegal, state, icount
  );

  modport slave (
    output run, fetch_ack, ir, flg,
    input  fetch_req, irie, raoe, rboe, rb, sel, sie, alu, clrf,
           retire, illegal, state, icount
  );

endinterface

// File: rtl/core8_dec.sv
// -----------------------------------------------------------------------------
// core8_dec
// Purely combinational opcode decoder: maps ir[15:10] to a control word.
// Ports:
//   i_opcode [5:0] : ir[15:10]
//   o_ctrl         : decoded control word (ctrl_t); legal=0 for any opcode
//                    outside the map, which includes every word with ir[14]=1
// -----------------------------------------------------------------------------
module core8_dec
  import core8_pkg::*;
(
  input  logic [5:0] i_opcode,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_ILLEGAL;
    case (i_opcode)
      //                      alu     2op   wr    flg   adc   clrf
      OPC_NOP: o_ctrl = mkCtrl(OP_A,   1'b0, 1'b0, 1'b0, 1'b0, CLRF_NONE);
      OPC_ADD: o_ctrl = mkCtrl(OP_ADD, 1'b1, 1'b1, 1'b1, 1'b0, CLRF_NONE);
      OPC_ADC: o_ctrl = mkCtrl(OP_ADD, 1'b1, 1'b1, 1'b1, 1'b1, CLRF_NONE);
      OPC_SUB: o_ctrl = mkCtrl(OP_SUB, 1'b1, 1'b1, 1'b1, 1'b0, CLRF_NONE);
      OPC_CP:  o_ctrl = mkCtrl(OP_SUB, 1'b1, 1'b0, 1'b1, 1'b0, CLRF_NONE);
      OPC_AND: o_ctrl = mkCtrl(OP_AND, 1'b1, 1'b1, 1'b1, 1'b0, CLRF_NONE);
      OPC_EOR: o_ctrl = mkCtrl(OP_EOR, 1'b1, 1'b1, 1'b1, 1'b0, CLRF_NONE);
      OPC_OR:  o_ctrl = mkCtrl(OP_OR,  1'b1, 1'b1, 1'b1, 1'b0, CLRF_NONE);
      OPC_INC: o_ctrl = mkCtrl(OP_INC, 1'b0, 1'b1, 1'b1, 1'b0, CLRF_NONE);
      OPC_DEC: o_ctrl = mkCtrl(OP_DEC, 1'b0, 1'b1, 1'b1, 1'b0, CLRF_NONE);
      OPC_CLC: o_ctrl = mkCtrl(OP_A,   1'b0, 1'b0, 1'b0, 1'b0, CLRF_CARRY);
      default: o_ctrl = CTRL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/core8_seq.sv
// -----------------------------------------------------------------------------
// core8_seq
// Multi-cycle FETCH -> DECODE -> EXEC sequencer for the 8-bit core datapath.
// Fetches through a run/fetch_req/fetch_ack handshake, registers the decoded
// control word in DECODE, drives GPR/ALU/SREG controls in EXEC and counts
// retired instructions.
// Parameter CNT_W : width of icount (wraps at 2^CNT_W).
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : core8_seq_if.master
//         in : run, fetch_ack, ir[15:0], flg[3:0] (flg[0] = carry)
//         out: fetch_req, irie, raoe, rboe, rb[3:0], sel, sie, alu[3:0],
//              clrf[3:0], retire, illegal, state[1:0], icount[CNT_W-1:0]
// -----------------------------------------------------------------------------
module core8_seq
  import core8_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  core8_seq_if.master  bus
);

  state_t           r_state;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_icount;
  ctrl_t            w_decCtrl;

  // The register selects in ir[9:4] belong to the datapath and only flg[0]
  // influences sequencing.
  logic w_unusedBits;
  assign w_unusedBits = ^{bus.ir[9:4], bus.flg[3:1]};

  core8_dec u_dec (
    .i_opcode (bus.ir[15:10]),
    .o_ctrl   (w_decCtrl)
  );

  // State, control word and retire counter. The control word is captured in
  // DECODE, when IR already holds the fetched instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_FETCH;
      r_ctrl   <= '0;
      r_icount <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (bus.fetch_ack && bus.run) r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          r_ctrl  <= w_decCtrl;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (r_ctrl.legal) r_icount <= r_icount + 1'b1;
          r_state <= ST_FETCH;
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // Control lines decode from registered state and control word only, so an
  // asynchronous reset drops sel/sie before the next edge. fetch_req/irie
  // follow run and fetch_ack combinationally so IR loads on the ack edge;
  // the ADC carry choice uses flg[0] as it stands during EXEC.
  always_comb begin
    bus.fetch_req = 1'b0;
    bus.irie      = 1'b0;
    bus.raoe      = 1'b0;
    bus.rboe      = 1'b0;
    bus.rb        = 4'd0;
    bus.sel       = 1'b0;
    bus.sie       = 1'b0;
    bus.alu       = OP_A;
    bus.clrf      = CLRF_NONE;
    bus.retire    = 1'b0;
    bus.illegal   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        bus.fetch_req = bus.run;
        bus.irie      = bus.fetch_ack & bus.run;
      end
      ST_EXEC: begin
        bus.raoe = 1'b1;
        if (r_ctrl.twoOp) begin
          bus.rboe = 1'b1;
          bus.rb   = bus.ir[3:0];
        end
        bus.alu     = (r_ctrl.useCarry && bus.flg[0]) ? OP_ADC1 : r_ctrl.alu;
        bus.sel     = r_ctrl.wr;
        bus.sie     = r_ctrl.flagUpd;
        bus.clrf    = r_ctrl.clrf;
        bus.retire  = r_ctrl.legal;
        bus.illegal = ~r_ctrl.legal;
      end
      default: ;
    endcase
  end

  assign bus.state  = r_state;
  assign bus.icount = r_icount;

endmodule

// File: tb/tb_core8_seq.sv
// -----------------------------------------------------------------------------
// tb_core8_seq
// Drives two core8_seq instances from the same stimulus: the main one with
// CNT_W=16 wired to a behavioural IR/GPR/ALU/SREG datapath, and a CNT_W=2 copy
// used to observe counter wrap. Architectural results are predicted by an
// instruction-level model (refR/refC/refCount).
// -----------------------------------------------------------------------------
module tb_core8_seq;

  logic clk = 1'b0;
  logic rst;

  core8_seq_if #(.CNT_W(16)) bus ();
  core8_seq_if #(.CNT_W(2))  bus2 ();

  core8_seq #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  core8_seq #(.CNT_W(2)) dutWrap (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  assign bus2.run       = bus.run;
  assign bus2.fetch_ack = bus.fetch_ack;
  assign bus2.ir        = bus.ir;
  assign bus2.flg       = bus.flg;

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] instWord;
  logic        pokeEn;
  logic [4:0]  pokeIdx;
  logic [7:0]  pokeVal;
  logic [7:0]  gpr [16];

  logic [7:0]  refR [16];
  logic        refC;
  int          refCount;

  logic [3:0]  exAlu, exRb, exClrf;
  logic        exSel, exSie, exRboe, exRetire, exIllegal;

  // Behavioural datapath: operand fetch and ALU8
  logic [7:0] opA, opB, envRes;
  logic       envCout, envCvalid;
  logic [3:0] envFlg;

  always_comb begin
    opA       = bus.raoe ? gpr[bus.ir[7:4]] : 8'h00;
    opB       = bus.rboe ? gpr[bus.rb] : 8'h00;
    envRes    = opA;
    envCout   = 1'b0;
    envCvalid = 1'b0;
    case (bus.alu)
      4'b1001: envRes = opA + 8'd1;
      4'b1010: envRes = opA - 8'd1;
      4'b1100: begin {envCout, envRes} = {1'b0, opA} + {1'b0, opB}; envCvalid = 1'b1; end
      4'b1101: begin {envCout, envRes} = {1'b0, opA} + {1'b0, opB} + 9'd1; envCvalid = 1'b1; end
      4'b1111: begin envRes = opA - opB; envCout = (opA < opB); envCvalid = 1'b1; end
      4'b0000: envRes = opA & opB;
      4'b0010: envRes = opA ^ opB;
      4'b0100: envRes = opA | opB;
      default: ;
    endcase
    envFlg = bus.flg;
    if (bus.sie) begin
      envFlg[1] = (envRes == 8'h00);
      if (envCvalid) envFlg[0] = envCout;
    end
    envFlg = envFlg & bus.clrf;
  end

  // Datapath registers: IR, GPR file, SREG; plus a poke port for presets
  always @(posedge clk) begin
    if (rst) begin
      bus.ir  <= 16'h0000;
      bus.flg <= 4'h0;
    end else begin
      if (bus.irie) bus.ir <= instWord;
      if (bus.sel) gpr[bus.ir[7:4]] <= envRes;
      bus.flg <= envFlg;
      if (pokeEn) begin
        if (pokeIdx[4]) bus.flg[0] <= pokeVal[0];
        else gpr[pokeIdx[3:0]] <= pokeVal;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Instruction-level reference: architectural effect of one instruction
  task automatic refStep(input logic [15:0] inst, output bit legal, output int d);
    int a, b, s;
    d = int'(inst[7:4]);
    a = int'(refR[inst[7:4]]);
    b = int'(refR[inst[3:0]]);
    legal = 1'b1;
    case (inst[15:10])
      6'b000000: ;
      6'b000011: begin s = a + b;             refC = (s > 255); refR[d] = 8'(s); end
      6'b000111: begin s = a + b + int'(refC); refC = (s > 255); refR[d] = 8'(s); end
      6'b000110: begin refC = (a < b); refR[d] = 8'(a - b); end
      6'b000101: refC = (a < b);
      6'b001000: refR[d] = 8'(a & b);
      6'b001010: refR[d] = 8'(a ^ b);
      6'b001011: refR[d] = 8'(a | b);
      6'b001001: refR[d] = 8'(a + 1);
      6'b001100: refR[d] = 8'(a - 1);
      6'b000001: refC = 1'b0;
      default:   legal = 1'b0;
    endcase
    if (legal) refCount++;
  endtask

  task automatic pokeReg(input int idx, input logic [7:0] val);
    pokeEn  = 1'b1;
    pokeIdx = 5'(idx);
    pokeVal = val;
    if (idx == 16) refC = val[0];
    else refR[idx] = val;
    @(negedge clk);
    pokeEn = 1'b0;
  endtask

  // One instruction through FETCH/DECODE/EXEC, starting at a negedge in FETCH
  task automatic applyStimulus(input logic [15:0] inst, input bit dropRun);
    bit legal;
    int d;
    refStep(inst, legal, d);
    instWord      = inst;
    bus.fetch_ack = 1'b1;
    bus.run       = 1'b1;
    #1;
    checkOutput("fetchIrie", 32'(bus.irie), 32'd1);
    checkOutput("fetchReq", 32'(bus.fetch_req), 32'd1);
    @(negedge clk);
    bus.fetch_ack = 1'b0;
    if (dropRun) bus.run = 1'b0;
    checkOutput("stDecode", 32'(bus.state), 32'd1);
    checkOutput("decodeIdle", 32'({bus.irie, bus.raoe, bus.rboe, bus.sel, bus.sie}), 32'd0);
    @(negedge clk);
    checkOutput("stExec", 32'(bus.state), 32'd2);
    exAlu     = bus.alu;
    exRb      = bus.rb;
    exClrf    = bus.clrf;
    exSel     = bus.sel;
    exSie     = bus.sie;
    exRboe    = bus.rboe;
    exRetire  = bus.retire;
    exIllegal = bus.illegal;
    checkOutput("execRaoe", 32'(bus.raoe), 32'd1);
    checkOutput("retire", 32'(bus.retire), 32'(legal));
    checkOutput("illegal", 32'(bus.illegal), 32'(!legal));
    @(negedge clk);
    checkOutput("stFetch", 32'(bus.state), 32'd0);
    checkOutput("pulseEnd", 32'({bus.retire, bus.illegal}), 32'd0);
    checkOutput("clrfIdle", 32'(bus.clrf), 32'hF);
    checkOutput("gprDest", 32'(gpr[d]), 32'(refR[d]));
    checkOutput("carry", 32'(bus.flg[0]), 32'(refC));
    checkOutput("icount", 32'(bus.icount), 32'(refCount & 16'hFFFF));
    checkOutput("icountW2", 32'(bus2.icount), 32'(refCount % 4));
  endtask

  function automatic logic [5:0] pickOp(input int k);
    case (k)
      0:  return 6'b000000;
      1:  return 6'b000011;
      2:  return 6'b000111;
      3:  return 6'b000110;
      4:  return 6'b000101;
      5:  return 6'b001000;
      6:  return 6'b001010;
      7:  return 6'b001011;
      8:  return 6'b001001;
      9:  return 6'b001100;
      10: return 6'b000001;
      default: return 6'b111111;
    endcase
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the end of stimulus");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] inst;
    int k;
    rst           = 1'b1;
    bus.run       = 1'b0;
    bus.fetch_ack = 1'b0;
    instWord      = 16'h0000;
    pokeEn        = 1'b0;
    pokeIdx       = 5'd0;
    pokeVal       = 8'h00;
    refC          = 1'b0;
    refCount      = 0;

    // Reset state
    @(negedge clk);
    checkOutput("rstState", 32'(bus.state), 32'd0);
    checkOutput("rstIcount", 32'(bus.icount), 32'd0);
    checkOutput("rstFetchReqRun0", 32'(bus.fetch_req), 32'd0);
    checkOutput("rstAlu", 32'(bus.alu), 32'h8);
    checkOutput("rstClrf", 32'(bus.clrf), 32'hF);
    checkOutput("rstRb", 32'(bus.rb), 32'd0);
    checkOutput("rstEnables", 32'({bus.irie, bus.raoe, bus.rboe, bus.sel, bus.sie}), 32'd0);
    bus.run = 1'b1;
    #1;
    checkOutput("rstFetchReqRun1", 32'(bus.fetch_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) pokeReg(i, 8'(i * 17));

    // ADD R1,R2 with R1=5, R2=7
    pokeReg(1, 8'd5);
    pokeReg(2, 8'd7);
    applyStimulus(16'h0C12, 1'b0);
    checkOutput("addRboe", 32'(exRboe), 32'd1);
    checkOutput("addRb", 32'(exRb), 32'd2);
    checkOutput("addAlu", 32'(exAlu), 32'hC);
    checkOutput("addSelSie", 32'({exSel, exSie}), 32'h3);
    checkOutput("addResult", 32'(gpr[1]), 32'd12);
    checkOutput("addIcount", 32'(bus.icount), 32'd1);

    // ADC R0,R1 with carry set, R0=FF, R1=00
    pokeReg(0, 8'hFF);
    pokeReg(1, 8'h00);
    pokeReg(16, 8'h01);
    applyStimulus(16'h1C01, 1'b0);
    checkOutput("adcAlu", 32'(exAlu), 32'hD);
    checkOutput("adcResult", 32'(gpr[0]), 32'h00);

    // CP R2,R3 then CLC
    pokeReg(2, 8'h09);
    pokeReg(3, 8'h04);
    applyStimulus(16'h1423, 1'b0);
    checkOutput("cpSelSie", 32'({exSel, exSie}), 32'h1);
    checkOutput("cpDestKept", 32'(gpr[2]), 32'h09);
    pokeReg(16, 8'h01);
    applyStimulus(16'h0400, 1'b0);
    checkOutput("clcClrf", 32'(exClrf), 32'hE);
    checkOutput("clcCarry", 32'(bus.flg[0]), 32'd0);

    // Illegal opcodes
    applyStimulus(16'hFC00, 1'b0);
    checkOutput("illFlag", 32'(exIllegal), 32'd1);
    checkOutput("illSelSie", 32'({exSel, exSie, exRetire}), 32'd0);
    inst = 16'($urandom) | 16'h4000;
    applyStimulus(inst, 1'b0);
    checkOutput("ir14Flag", 32'(exIllegal), 32'd1);
    checkOutput("ir14SelSie", 32'({exSel, exSie}), 32'd0);

    // run dropped during DECODE: INC R3 completes, then the sequencer idles
    applyStimulus(16'h2430, 1'b1);
    checkOutput("idleFetchReq", 32'(bus.fetch_req), 32'd0);
    bus.fetch_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idleState", 32'(bus.state), 32'd0);
      checkOutput("idleIrie", 32'(bus.irie), 32'd0);
    end
    bus.fetch_ack = 1'b0;
    checkOutput("idleIcount", 32'(bus.icount), 32'(refCount));
    bus.run = 1'b1;

    // Randomized instruction mix
    for (int i = 0; i < 30; i++) begin
      pokeReg(int'($urandom_range(0, 15)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) pokeReg(16, 8'($urandom_range(0, 1)));
      k = int'($urandom_range(0, 11));
      inst = {pickOp(k), 10'($urandom)};
      if (k == 11) inst = 16'($urandom) | 16'h4000;
      applyStimulus(inst, 1'b0);
    end

    // Asynchronous reset in the middle of EXEC of ADD R5,R6
    pokeReg(5, 8'h10);
    pokeReg(6, 8'h01);
    instWord      = 16'h0C56;
    bus.fetch_ack = 1'b1;
    @(negedge clk);
    bus.fetch_ack = 1'b0;
    @(negedge clk);
    checkOutput("preRstSel", 32'(bus.sel), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncSelSie", 32'({bus.sel, bus.sie}), 32'd0);
    checkOutput("asyncState", 32'(bus.state), 32'd0);
    checkOutput("asyncIcount", 32'(bus.icount), 32'd0);
    checkOutput("asyncIcountW2", 32'(bus2.icount), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    refCount = 0;
    refC     = 1'b0;
    checkOutput("lostWrite", 32'(gpr[5]), 32'h10);

    // Four retires wrap the 2-bit counter
    repeat (4) applyStimulus(16'h0000, 1'b0);
    checkOutput("wrapW2", 32'(bus2.icount), 32'd0);
    checkOutput("wrapW16", 32'(bus.icount), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core8_seq.md
Name: core8_seq

Overview:
- Multi-cycle sequencer for the 8-bit core datapath: IR load, GPR file, ALU8 and 4-bit status register.
- Replaces the free-running fetch/IDEX toggle with a handshaked fetch, a registered decode stage and an execute/writeback stage.
- Drives every datapath control line: IR enable, GPR output and write enables, ALU opcode, SREG enable and clear mask.
- Sits between the instruction source and the datapath; counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- run  in  1  1 = sequencer may issue new fetches
- fetch_ack  in  1  instruction source presents a valid inst this cycle
- ir  in  16  IR register output
- flg  in  4  SREG flags; flg[0] = carry
- fetch_req  out  1  request for the next instruction
- irie  out  1  IR input enable
- raoe  out  1  GPR a-port output enable
- rboe  out  1  GPR b-port output enable
- rb  out  4  GPR b-port select
- sel  out  1  GPR write enable (destination = ir[7:4])
- sie  out  1  SREG input enable
- alu  out  4  ALU opcode
- clrf  out  4  SREG clear mask (0 bit clears that flag)
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  one-cycle pulse on an undefined opcode
- state  out  2  current state (debug)
- icount  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- States: FETCH=00, DECODE=01, EXEC=10; encoding 11 is unused and recovers to FETCH.
- On rst assertion:
  - state=FETCH, icount=0, decoded control word cleared.
  - Outputs: fetch_req=run, all other enables 0, rb=0, alu=4'b1000, clrf=4'b1111.
- FETCH:
  - fetch_req=run.
  - irie=fetch_ack&run, combinational; IR captures inst at that edge.
  - Go to DECODE on fetch_ack&run; otherwise stay in FETCH.
  - fetch_ack with run=0 is ignored.
- DECODE:
  - All datapath enables 0.
  - Decode ir[15:10] into a registered control word (alu, two-operand, write, flag-update, clrf, legal). Sub-module: core8_dec.
  - Always go to EXEC.
- EXEC:
  - raoe=1. rboe=1 and rb=ir[3:0] for two-operand ops.
  - alu, sel, sie and clrf come from the control word.
  - GPR and SREG update at this edge.
  - retire=1 for legal ops, illegal=1 otherwise (no writes).
  - Always go to FETCH.
- Latency: 3 cycles per instruction when fetch_ack is already high in FETCH.
- Opcode map (ir[15:10] -> alu / sel / sie / operands):
  - 000000 NOP -> 1000 / 0 / 0 / none
  - 000011 ADD -> 1100 / 1 / 1 / 2
  - 000111 ADC -> flg[0] ? 1101 : 1100 / 1 / 1 / 2. flg[0] is sampled combinationally in EXEC, not in DECODE.
  - 000110 SUB -> 1111 / 1 / 1 / 2
  - 000101 CP -> 1111 / 0 / 1 / 2 (flags only)
  - 001000 AND -> 0000 / 1 / 1 / 2
  - 001010 EOR -> 0010 / 1 / 1 / 2
  - 001011 OR -> 0100 / 1 / 1 / 2
  - 001001 INC -> 1001 / 1 / 1 / 1
  - 001100 DEC -> 1010 / 1 / 1 / 1
  - 000001 CLC -> 1000 / 0 / 0 / none, with clrf=1110
- clrf=1111 in all other cases, and in every state except EXEC.
- Any other opcode, or ir[14]=1, is illegal.
- run deasserted in DECODE/EXEC: the in-flight instruction completes, then the sequencer idles in FETCH with fetch_req=0.
- icount: +1 on each retire; wraps from 2^CNT_W-1 to 0. Illegal ops do not count.
- rst mid-EXEC: sel/sie drop immediately (asynchronous); the datapath write is lost.

Decomposition:
- core8_pkg holds:
  - state encodings;
  - opcode constants;
  - ALU op constants (OP_A=1000, OP_INC=1001, OP_DEC=1010, OP_ADD=1100, OP_ADC1=1101, OP_SUB=1111, OP_AND=0000, OP_EOR=0010, OP_OR=0100);
  - control-word field layout.
- One sub-module: core8_dec, a combinational opcode-to-control-word decoder.

Test Plan:
- Reset, then run=1, fetch_ack=1, inst=0x0C12 (ADD, ra=1, rb=2) with R1=5, R2=7. Required: irie in cycle 0; in cycle 2, raoe=rboe=1, rb=2, alu=1100, sel=sie=1; R1=12 afterwards; retire pulse; icount=1.
- ADC with flg[0]=1, R0=0xFF, R1=0x00, inst=0x1C01. Required: alu=1101 in EXEC; R0=0x00.
- CP (0x1423) then CLC (0x0400). Required: CP gives sel=0, sie=1, destination register unchanged. CLC gives clrf=1110 for one cycle and flg[0] clears.
- Illegal 0xFC00, and any ir[14]=1 word. Required: illegal=1 for one cycle; sel=sie=0; icount unchanged; returns to FETCH.
- run=0 asserted during DECODE. Required: EXEC completes; then fetch_req=0; fetch_ack=1 is ignored and state stays 00.
- rst pulsed asynchronously mid-EXEC. Required: sel and sie drop before the next edge, state=00, icount=0. With CNT_W=2, 4 retires wrap icount to 0.
